phase_sequencer: RTL and testbench

- Multicycle instruction-phase controller: generates the one-hot 4-bit `start` phase strobes that drive the fetch / decode / execute / writeback stages.
- Owns run / step / halt control, memory-stall freezing, and the `pc_update` (branch-taken) signal consumed by fetch.
- Fetch latches its instruction on the rising edge of `start[0]` and updates PC on the falling edge of `start[3]`. This block guarantees clean edges and a stable `pc_update` around both.

---
 rtl/phase_sequencer_if.sv | 27 ++
 rtl/phase_sequencer.sv | 134 +++++++++++++
 tb/tb_phase_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// Command/status bundle between the instruction-phase sequencer and its controller.
// The sequencer is the slave; whoever issues run/step/halt is the master.
interface phase_sequencer_if #(
  parameter int ICNT_W = 32
);
  logic              run;
  logic              step;
  logic              halt_req;
  logic              stall;
  logic              branch_taken;
  logic [3:0]        start;
  logic              pc_update;
  logic [1:0]        phase_idx;
  logic              busy;
  logic              halted;
  logic [ICNT_W-1:0] instr_cnt;

  modport master (
    output run, step, halt_req, stall, branch_taken,
    input  start, pc_update, phase_idx, busy, halted, instr_cnt
  );

  modport slave (
    input  run, step, halt_req, stall, branch_taken,
    output start, pc_update, phase_idx, busy, halted, instr_cnt
  );
endinterface

// File: rtl/phase_sequencer.sv
// Multicycle instruction-phase controller: one-hot fetch/decode/execute/writeback
// strobes with run/step/halt control, stall freezing and branch pc_update.
module phase_sequencer #(
  parameter int PHASE_CYCLES = 1,
  parameter int ICNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  phase_sequencer_if.slave   bus
);

  localparam int DW_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALTED} state_t;

  state_t            state_q, state_d;
  logic [3:0]        start_q, start_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic              halt_pend_q, halt_pend_d;
  logic              pc_q, pc_d;
  logic              pc_drop_q, pc_drop_d;
  logic [ICNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]        phase_q, phase_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  logic              active;
  logic              legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= '0;
      dwell_q     <= '0;
      halt_pend_q <= 1'b0;
      pc_q        <= 1'b0;
      pc_drop_q   <= 1'b0;
      cnt_q       <= '0;
      phase_q     <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      dwell_q     <= dwell_d;
      halt_pend_q <= halt_pend_d;
      pc_q        <= pc_d;
      pc_drop_q   <= pc_drop_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign active = (state_q == S_RUN) || (state_q == S_STEP);
  // A strobe must be one-hot and present exactly when an instruction is in flight.
  assign legal  = ((start_q & (start_q - 4'd1)) == 4'd0) && (active == (start_q != 4'd0));

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    dwell_d     = dwell_q;
    halt_pend_d = halt_pend_q;
    pc_d        = pc_q;
    pc_drop_d   = 1'b0;
    cnt_d       = cnt_q;

    // pc_update survives the edge where start[3] falls and clears one edge later.
    if (pc_drop_q) pc_d = 1'b0;

    if (!legal) begin
      state_d     = S_IDLE;
      start_d     = '0;
      dwell_d     = '0;
      halt_pend_d = 1'b0;
      pc_d        = 1'b0;
    end else if (!active) begin
      dwell_d     = '0;
      halt_pend_d = 1'b0;
      if (bus.run) begin
        state_d = S_RUN;
        start_d = 4'b0001;
      end else if (bus.step) begin
        state_d = S_STEP;
        start_d = 4'b0001;
      end
    end else begin
      halt_pend_d = halt_pend_q | bus.halt_req;
      if (!bus.stall) begin
        if (start_q[2] && bus.branch_taken) pc_d = 1'b1;
        if (dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + 1'b1;
        end else begin
          dwell_d = '0;
          if (!start_q[3]) begin
            start_d = start_q << 1;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            pc_drop_d = 1'b1;
            if (state_q == S_RUN && bus.run && !halt_pend_d) begin
              start_d = 4'b0001;
            end else begin
              start_d     = '0;
              state_d     = S_HALTED;
              halt_pend_d = 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    phase_d = 2'd0;
    case (start_d)
      4'b0010: phase_d = 2'd1;
      4'b0100: phase_d = 2'd2;
      4'b1000: phase_d = 2'd3;
      default: phase_d = 2'd0;
    endcase
    busy_d   = (state_d == S_RUN) || (state_d == S_STEP);
    halted_d = (state_d == S_HALTED);
  end

  assign bus.start     = start_q;
  assign bus.pc_update = pc_q;
  assign bus.phase_idx = phase_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus randomized
// stimulus against an instruction-level reference model, at PHASE_CYCLES 1 and 3.
module tb_phase_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phase_sequencer_if #(.ICNT_W(32)) if1 ();
  phase_sequencer_if #(.ICNT_W(4))  if3 ();

  phase_sequencer #(.PHASE_CYCLES(1), .ICNT_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  phase_sequencer #(.PHASE_CYCLES(3), .ICNT_W(4))  dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int checks   = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      assert ((if1.start & (if1.start - 4'd1)) == 4'd0) else $error("dut1 start not one-hot: %b", if1.start);
      assert ((if3.start & (if3.start - 4'd1)) == 4'd0) else $error("dut3 start not one-hot: %b", if3.start);
    end
  end

  // Reference model: mode 0 idle, 1 run, 2 step, 3 halted; act = instruction in flight
  typedef struct {
    int          mode;
    bit          act;
    int          ph;
    int          dw;
    bit          hp;
    bit          pc;
    bit          drop;
    int unsigned cnt;
  } mdl_t;

  function automatic mdl_t m_reset();
    mdl_t z;
    z.mode = 0; z.act = 0; z.ph = 0; z.dw = 0;
    z.hp = 0; z.pc = 0; z.drop = 0; z.cnt = 0;
    return z;
  endfunction

  function automatic mdl_t m_step(mdl_t m, int pcyc, int cw, bit r, bit s, bit h, bit st, bit b);
    mdl_t n = m;
    n.drop = 0;
    if (m.drop) n.pc = 0;
    if (!m.act) begin
      n.hp = 0;
      if (r)      begin n.mode = 1; n.act = 1; n.ph = 0; n.dw = 0; end
      else if (s) begin n.mode = 2; n.act = 1; n.ph = 0; n.dw = 0; end
    end else begin
      if (h) n.hp = 1;
      if (!st) begin
        if (m.ph == 2 && b) n.pc = 1;
        if (m.dw + 1 < pcyc) n.dw = m.dw + 1;
        else begin
          n.dw = 0;
          if (m.ph < 3) n.ph = m.ph + 1;
          else begin
            n.cnt = m.cnt + 1;
            if (cw < 32) n.cnt = n.cnt % (32'd1 << cw);
            n.drop = 1;
            if (m.mode == 1 && r && !n.hp) n.ph = 0;
            else begin n.act = 0; n.ph = 0; n.mode = 3; n.hp = 0; end
          end
        end
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] m_start(mdl_t m);
    return m.act ? (4'b0001 << m.ph) : 4'b0000;
  endfunction

  function automatic logic [1:0] m_phase(mdl_t m);
    return m.act ? 2'(m.ph) : 2'd0;
  endfunction

  task automatic drive(input bit r, input bit s, input bit h, input bit st, input bit b);
    if1.run = r; if1.step = s; if1.halt_req = h; if1.stall = st; if1.branch_taken = b;
    if3.run = r; if3.step = s; if3.halt_req = h; if3.stall = st; if3.branch_taken = b;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    cyc(); cyc();
    checks++; if (if1.start !== 4'b0) begin failures++; $display("FAIL reset_start got=%b exp=0000", if1.start); end
    checks++; if (if1.pc_update !== 1'b0) begin failures++; $display("FAIL reset_pc_update got=%b exp=0", if1.pc_update); end
    checks++; if (if1.phase_idx !== 2'd0) begin failures++; $display("FAIL reset_phase_idx got=%0d exp=0", if1.phase_idx); end
    checks++; if (if1.busy !== 1'b0 || if1.halted !== 1'b0) begin failures++; $display("FAIL reset_busy_halted got=%b%b exp=00", if1.busy, if1.halted); end
    checks++; if (if1.instr_cnt !== 32'd0) begin failures++; $display("FAIL reset_instr_cnt got=%0d exp=0", if1.instr_cnt); end
    checks++;
    if ({if3.start, if3.pc_update, if3.phase_idx, if3.busy, if3.halted, if3.instr_cnt} !== 13'd0) begin
      failures++; $display("FAIL reset_dut3 got start=%b pc=%b cnt=%0d exp all zero", if3.start, if3.pc_update, if3.instr_cnt);
    end
    rst_n = 1'b1;
    cyc();
    checks++; if (if1.start !== 4'b0 || if1.busy !== 1'b0) begin failures++; $display("FAIL reset_idle_hold got start=%b busy=%b exp 0000/0", if1.start, if1.busy); end
  endtask

  task automatic test_run3();
    logic [3:0] exp;
    do_reset();
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      cyc();
      exp = 4'b0001 << (k % 4);
      checks++;
      if (if1.start !== exp || if1.phase_idx !== 2'(k % 4)) begin
        failures++; $display("FAIL run3_seq k=%0d got start=%b idx=%0d exp start=%b idx=%0d", k, if1.start, if1.phase_idx, exp, k % 4);
      end
    end
    cyc();
    checks++;
    if (if1.start !== 4'b0001 || if1.instr_cnt !== 32'd3 || if1.busy !== 1'b1 || if1.halted !== 1'b0) begin
      failures++; $display("FAIL run3_end got start=%b cnt=%0d busy=%b halted=%b exp 0001/3/1/0", if1.start, if1.instr_cnt, if1.busy, if1.halted);
    end
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k < 4; k++) begin
      cyc();
      exp = 4'b0001 << k;
      checks++; if (if1.start !== exp) begin failures++; $display("FAIL run_drop_complete k=%0d got=%b exp=%b", k, if1.start, exp); end
    end
    cyc();
    checks++;
    if (if1.start !== 4'b0 || if1.halted !== 1'b1 || if1.busy !== 1'b0 || if1.instr_cnt !== 32'd4) begin
      failures++; $display("FAIL run_drop_halt got start=%b halted=%b busy=%b cnt=%0d exp 0000/1/0/4", if1.start, if1.halted, if1.busy, if1.instr_cnt);
    end
  endtask

  task automatic test_stall();
    int n0100 = 0;
    int first = 0;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      drive(1, 0, 0, (e >= 4 && e <= 8), 0);
      cyc();
      if (e <= 10 && if1.start == 4'b0100) n0100++;
      if (first == 0 && if1.instr_cnt == 32'd1) first = e;
      if (e == 8) begin
        checks++; if (if1.start !== 4'b0100 || if1.phase_idx !== 2'd2) begin failures++; $display("FAIL stall_freeze got start=%b idx=%0d exp 0100/2", if1.start, if1.phase_idx); end
      end
    end
    checks++; if (n0100 != 6) begin failures++; $display("FAIL stall_dwell got=%0d cycles exp=6", n0100); end
    checks++; if (first != 10) begin failures++; $display("FAIL stall_latency got edge=%0d exp=10", first); end
  endtask

  task automatic test_branch();
    bit [9:1] bt_pat = 9'b101011000;
    bit [9:1] pc_exp = 9'b000011000;
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      drive(1, 0, 0, 0, bt_pat[e]);
      cyc();
      checks++;
      if (if1.pc_update !== pc_exp[e]) begin
        failures++; $display("FAIL branch_pc e=%0d got=%b exp=%b", e, if1.pc_update, pc_exp[e]);
      end
    end
  endtask

  task automatic test_halt_step();
    bit seen3 = 0;
    logic [3:0] exp;
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      drive(1, 0, (e == 7), 0, 0);
      cyc();
      if (e == 8) seen3 = (if1.start == 4'b1000);
    end
    checks++; if (!seen3) begin failures++; $display("FAIL halt_completes got phase3=0 exp=1"); end
    checks++;
    if (if1.start !== 4'b0 || if1.halted !== 1'b1 || if1.busy !== 1'b0 || if1.instr_cnt !== 32'd2) begin
      failures++; $display("FAIL halt_state got start=%b halted=%b busy=%b cnt=%0d exp 0000/1/0/2", if1.start, if1.halted, if1.busy, if1.instr_cnt);
    end
    for (int e = 10; e <= 15; e++) begin
      drive(0, (e == 10), 0, 0, 0);
      cyc();
      exp = (e <= 13) ? (4'b0001 << (e - 10)) : 4'b0000;
      checks++; if (if1.start !== exp) begin failures++; $display("FAIL step_seq e=%0d got=%b exp=%b", e, if1.start, exp); end
      if (e == 10) begin
        checks++; if (if1.busy !== 1'b1 || if1.halted !== 1'b0) begin failures++; $display("FAIL step_busy got busy=%b halted=%b exp 1/0", if1.busy, if1.halted); end
      end
      if (e == 14) begin
        checks++; if (if1.instr_cnt !== 32'd3 || if1.halted !== 1'b1) begin failures++; $display("FAIL step_end got cnt=%0d halted=%b exp 3/1", if1.instr_cnt, if1.halted); end
      end
    end
  endtask

  task automatic test_pc3();
    logic [3:0] exp;
    do_reset();
    drive(1, 0, 0, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (k <= 12) begin
        exp = 4'b0001 << ((k - 1) / 3);
        checks++; if (if3.start !== exp) begin failures++; $display("FAIL pc3_seq k=%0d got=%b exp=%b", k, if3.start, exp); end
      end
      if (k == 12) begin
        checks++; if (if3.instr_cnt !== 4'd0) begin failures++; $display("FAIL pc3_cnt_early got=%0d exp=0", if3.instr_cnt); end
      end
      if (k == 13) begin
        checks++; if (if3.instr_cnt !== 4'd1 || if3.start !== 4'b0001) begin failures++; $display("FAIL pc3_cnt got cnt=%0d start=%b exp 1/0001", if3.instr_cnt, if3.start); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit pc_seen = 0;
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      drive(1, 0, (e == 8), 0, (e == 8));
      cyc();
    end
    checks++;
    if (if3.start !== 4'b0100 || if3.pc_update !== 1'b1 || if3.busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre got start=%b pc=%b busy=%b exp 0100/1/1", if3.start, if3.pc_update, if3.busy);
    end
    drive(0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({if3.start, if3.pc_update, if3.phase_idx, if3.busy, if3.halted, if3.instr_cnt} !== 13'd0) begin
      failures++; $display("FAIL rstmid_async got start=%b pc=%b idx=%0d busy=%b halted=%b exp all zero", if3.start, if3.pc_update, if3.phase_idx, if3.busy, if3.halted);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      cyc();
      checks++;
      if (if3.start !== 4'b0 || if3.busy !== 1'b0 || if3.halted !== 1'b0 || if3.pc_update !== 1'b0) begin
        failures++; $display("FAIL rstmid_idle e=%0d got start=%b busy=%b halted=%b pc=%b exp idle", e, if3.start, if3.busy, if3.halted, if3.pc_update);
      end
    end
    drive(1, 0, 0, 0, 0);
    for (int e = 1; e <= 13; e++) begin
      cyc();
      if (if3.pc_update) pc_seen = 1;
    end
    checks++;
    if (if3.instr_cnt !== 4'd1 || if3.start !== 4'b0001 || if3.busy !== 1'b1 || pc_seen) begin
      failures++; $display("FAIL rstmid_no_residue got cnt=%0d start=%b busy=%b pc_seen=%b exp 1/0001/1/0", if3.instr_cnt, if3.start, if3.busy, pc_seen);
    end
  endtask

  task automatic test_random();
    mdl_t m1, m3;
    bit r = 0, s, h, st, b;
    int nfail = 0;
    do_reset();
    m1 = m_reset();
    m3 = m_reset();
    for (int c = 0; c < 3000 && nfail < 10; c++) begin
      if ($urandom_range(39) == 0) r = ~r;
      s  = ($urandom_range(9) == 0);
      h  = ($urandom_range(29) == 0);
      st = ($urandom_range(3) == 0);
      b  = 1'($urandom_range(1));
      drive(r, s, h, st, b);
      cyc();
      m1 = m_step(m1, 1, 32, r, s, h, st, b);
      m3 = m_step(m3, 3, 4, r, s, h, st, b);
      checks++;
      if ({if1.start, if1.pc_update, if1.phase_idx, if1.busy, if1.halted} !==
          {m_start(m1), m1.pc, m_phase(m1), (m1.mode == 1 || m1.mode == 2), (m1.mode == 3)} ||
          if1.instr_cnt !== m1.cnt) begin
        failures++; nfail++;
        $display("FAIL rand_pc1 c=%0d got start=%b pc=%b idx=%0d busy=%b halted=%b cnt=%0d exp start=%b pc=%b idx=%0d mode=%0d cnt=%0d",
                 c, if1.start, if1.pc_update, if1.phase_idx, if1.busy, if1.halted, if1.instr_cnt,
                 m_start(m1), m1.pc, m_phase(m1), m1.mode, m1.cnt);
      end
      checks++;
      if ({if3.start, if3.pc_update, if3.phase_idx, if3.busy, if3.halted} !==
          {m_start(m3), m3.pc, m_phase(m3), (m3.mode == 1 || m3.mode == 2), (m3.mode == 3)} ||
          if3.instr_cnt !== 4'(m3.cnt)) begin
        failures++; nfail++;
        $display("FAIL rand_pc3 c=%0d got start=%b pc=%b idx=%0d busy=%b halted=%b cnt=%0d exp start=%b pc=%b idx=%0d mode=%0d cnt=%0d",
                 c, if3.start, if3.pc_update, if3.phase_idx, if3.busy, if3.halted, if3.instr_cnt,
                 m_start(m3), m3.pc, m_phase(m3), m3.mode, m3.cnt);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_run3();
    test_stall();
    test_branch();
    test_halt_step();
    test_pc3();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
